// File: rtl/fifo_trace_writer_if.sv
// fifo_trace_writer_if: AXI-stream beat bundle tapped by the trace writer.
//   tdata  - beat data, IN_WIDTH bits
//   tkeep  - byte enables, contiguous from bit 0, all-ones on non-last beats
//   tvalid - beat present; there is no tready, so every valid beat is consumed
//   tlast  - last beat of the packet
// The master modport is the stream source; the slave modport is the passive tap.
interface fifo_trace_writer_if #(
    parameter int unsigned IN_WIDTH = 64
);
    logic [IN_WIDTH-1:0]   tdata;
    logic [IN_WIDTH/8-1:0] tkeep;
    logic                  tvalid;
    logic                  tlast;

    modport master (output tdata, tkeep, tvalid, tlast);
    modport slave  (input  tdata, tkeep, tvalid, tlast);
endinterface

// File: rtl/fifo_trace_writer.sv
// fifo_trace_writer: passive capture front-end for the overwrite-on-full FIFO.
// Packs whole packets from a tapped AXI stream into self-describing entries of
// OUT_WIDTH bits: BEATS payload beats in the low bits, a metadata field in the top
// META_WIDTH bits. One fifo_wr_en pulse is issued per entry, and entries written
// while the FIFO is full are counted because they overwrite older data.
//
// Ports:
//   wr_clk        - capture and FIFO write clock
//   reset         - synchronous, active-high
//   capture_en    - capture enable, acted on only at packet boundaries
//   s_axis        - tapped stream (slave modport, no backpressure)
//   fifo_full     - FIFO full flag
//   fifo_wr_en    - one-cycle write strobe
//   fifo_data     - entry, valid while fifo_wr_en is high
//   pkt_cnt       - packets fully captured, wraps
//   overwrite_cnt - entries written while full, saturates
//   busy          - high while a packet is being captured
//
// Metadata layout (relative to the metadata field):
//   [63:48] seq  [47:16] timestamp of first beat  [15:8] byte count
//   [7] sof  [6] eof  [5] overflow  [4:0] zero
module fifo_trace_writer #(
    parameter int unsigned IN_WIDTH   = 64,
    parameter int unsigned OUT_WIDTH  = 512,
    parameter int unsigned META_WIDTH = 64,
    parameter int unsigned BEATS      = (OUT_WIDTH - META_WIDTH) / IN_WIDTH
) (
    input  logic                 wr_clk,
    input  logic                 reset,
    input  logic                 capture_en,
    fifo_trace_writer_if.slave   s_axis,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [OUT_WIDTH-1:0] fifo_data,
    output logic [31:0]          pkt_cnt,
    output logic [31:0]          overwrite_cnt,
    output logic                 busy
);

    localparam int unsigned KEEP_W = IN_WIDTH / 8;
    localparam int unsigned PAY_W  = BEATS * IN_WIDTH;
    localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W  = $clog2(KEEP_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StSkip
    } state_e;

    state_e                 r_state;
    state_e                 w_state_d;
    logic                   r_in_pkt;
    logic [31:0]            r_ts;
    logic [15:0]            r_seq;
    logic [IDX_W-1:0]       r_idx;
    logic [PAY_W-1:0]       r_payload;
    logic [31:0]            r_entry_ts;
    logic                   r_entry_sof;
    logic                   r_wr_en;
    logic [OUT_WIDTH-1:0]   r_data;
    logic [31:0]            r_pkt_cnt;
    logic [31:0]            r_overwrite_cnt;
    logic                   r_ovf;

    logic                   w_sof_beat;
    logic                   w_take;
    logic                   w_close;
    logic                   w_first;
    logic [PAY_W-1:0]       w_payload;
    logic [31:0]            w_ts_e;
    logic                   w_sof_e;
    logic [CNT_W-1:0]       w_keep_cnt;
    logic [7:0]             w_bytes;
    logic                   w_ovf;
    logic [META_WIDTH-1:0]  w_meta;
    logic [OUT_WIDTH-1:0]   w_entry;

    // A beat seen while no packet is open starts a new packet.
    assign w_sof_beat = !r_in_pkt;

    // In IDLE only an enabled SOF beat is captured; CAPTURE takes every beat.
    assign w_take = s_axis.tvalid &&
                    (((r_state == StIdle) && capture_en && w_sof_beat) ||
                     (r_state == StCapture));
    assign w_close = w_take && (s_axis.tlast || (r_idx == LAST_IDX));
    assign w_first = (r_idx == '0);

    // A flag raised by a full write in this very cycle must still reach an entry
    // that closes on the same edge.
    assign w_ovf = r_ovf | (r_wr_en & fifo_full);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (s_axis.tvalid && capture_en && !s_axis.tlast) begin
                    w_state_d = w_sof_beat ? StCapture : StSkip;
                end
            end
            StCapture: begin
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_state_d = StIdle;
                end
            end
            StSkip: begin
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_keep_cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            w_keep_cnt = w_keep_cnt + CNT_W'(s_axis.tkeep[i]);
        end
        // Earlier beats of the entry are always full-keep.
        w_bytes = 8'({r_idx, 3'b000}) + 8'(w_keep_cnt);
    end

    always_comb begin
        // Starting a fresh entry clears stale beats so unused slots read zero.
        w_payload = w_first ? '0 : r_payload;
        for (int k = 0; k < BEATS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_payload[k*IN_WIDTH +: IN_WIDTH] = s_axis.tdata;
            end
        end
        w_ts_e  = w_first ? r_ts : r_entry_ts;
        w_sof_e = w_first ? (r_state == StIdle) : r_entry_sof;
    end

    always_comb begin
        w_meta        = '0;
        w_meta[63:48] = r_seq;
        w_meta[47:16] = w_ts_e;
        w_meta[15:8]  = w_bytes;
        w_meta[7]     = w_sof_e;
        w_meta[6]     = s_axis.tlast;
        w_meta[5]     = w_ovf;

        w_entry                                = '0;
        w_entry[PAY_W-1:0]                     = w_payload;
        w_entry[OUT_WIDTH-1 -: META_WIDTH]     = w_meta;
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_in_pkt <= 1'b0;
            r_ts     <= '0;
        end else begin
            r_state <= w_state_d;
            r_ts    <= r_ts + 32'd1;
            if (s_axis.tvalid) begin
                r_in_pkt <= !s_axis.tlast;
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_payload   <= '0;
            r_entry_ts  <= '0;
            r_entry_sof <= 1'b0;
            r_wr_en     <= 1'b0;
            r_data      <= '0;
            r_seq       <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            r_wr_en <= w_close;
            if (w_take) begin
                r_idx       <= w_close ? '0 : r_idx + IDX_W'(1);
                r_payload   <= w_payload;
                r_entry_ts  <= w_ts_e;
                r_entry_sof <= w_sof_e;
            end
            if (w_close) begin
                r_data <= w_entry;
            end
            if (w_take && s_axis.tlast) begin
                r_seq     <= r_seq + 16'd1;
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_overwrite_cnt <= '0;
            r_ovf           <= 1'b0;
        end else if (r_wr_en) begin
            if (fifo_full) begin
                r_ovf <= 1'b1;
                if (r_overwrite_cnt != 32'hFFFF_FFFF) begin
                    r_overwrite_cnt <= r_overwrite_cnt + 32'd1;
                end
            end else begin
                // This write carried the flag, so it has been reported.
                r_ovf <= 1'b0;
            end
        end
    end

    assign fifo_wr_en    = r_wr_en;
    assign fifo_data     = r_data;
    assign pkt_cnt       = r_pkt_cnt;
    assign overwrite_cnt = r_overwrite_cnt;
    assign busy          = (r_state == StCapture);

endmodule
